// File: rtl/alu_ctrl_stage.sv
// One-deep decode stage: turns a MIPS instruction word into an ALU control bundle behind a valid/ready skid-free register.
// Optional feature: define ILLEGAL_CNT_EN to add the saturating o_Illegal_Count output.
module alu_ctrl_stage #(
   parameter int CNT_WIDTH = 16
) (
   input  logic        i_Clock,
   input  logic        i_Reset_n,
   input  logic        i_Valid,
   output logic        o_Ready,
   input  logic [31:0] i_Instruction,
   input  logic        i_Flush,
   output logic        o_Valid,
   input  logic        i_Ready,
   output logic [3:0]  o_Control,
   output logic [4:0]  o_Shamt,
   output logic [4:0]  o_Rs,
   output logic [4:0]  o_Rt,
   output logic [4:0]  o_Write_Reg,
   output logic        o_Reg_Write,
   output logic        o_ALU_Src_Imm,
   output logic [31:0] o_Imm,
   output logic        o_Illegal
`ifdef ILLEGAL_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] o_Illegal_Count
`endif
);

   localparam logic [3:0] CTL_SLL  = 4'd0;
   localparam logic [3:0] CTL_SRL  = 4'd1;
   localparam logic [3:0] CTL_SRA  = 4'd2;
   localparam logic [3:0] CTL_SLLV = 4'd3;
   localparam logic [3:0] CTL_SRLV = 4'd4;
   localparam logic [3:0] CTL_SRAV = 4'd5;
   localparam logic [3:0] CTL_ADDU = 4'd6;
   localparam logic [3:0] CTL_SUBU = 4'd7;
   localparam logic [3:0] CTL_AND  = 4'd8;
   localparam logic [3:0] CTL_OR   = 4'd9;
   localparam logic [3:0] CTL_XOR  = 4'd10;
   localparam logic [3:0] CTL_NOR  = 4'd11;
   localparam logic [3:0] CTL_SLT  = 4'd12;
   localparam logic [3:0] CTL_JALR = 4'd13;
   localparam logic [3:0] CTL_LUI  = 4'd14;
   localparam logic [3:0] CTL_ILL  = 4'd15;

   if (CNT_WIDTH < 1) begin : g_bad_cnt_width
      $error("alu_ctrl_stage: CNT_WIDTH must be at least 1");
   end

   // Instruction fields
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rs_f;
   logic [4:0]  rt_f;
   logic [4:0]  rd_f;
   logic [4:0]  shamt_f;
   logic [15:0] imm16;

   assign opcode  = i_Instruction[31:26];
   assign rs_f    = i_Instruction[25:21];
   assign rt_f    = i_Instruction[20:16];
   assign rd_f    = i_Instruction[15:11];
   assign shamt_f = i_Instruction[10:6];
   assign funct   = i_Instruction[5:0];
   assign imm16   = i_Instruction[15:0];

   // Decoded bundle of the incoming word
   logic [3:0]  dec_ctl;
   logic        dec_legal;
   logic        dec_reg_write;
   logic        dec_src_imm;
   logic [4:0]  dec_write_reg;
   logic [31:0] dec_imm;

   always_comb begin
      dec_ctl       = CTL_ILL;
      dec_legal     = 1'b0;
      dec_reg_write = 1'b0;
      dec_src_imm   = 1'b0;
      dec_write_reg = 5'd0;
      dec_imm       = 32'd0;

      if (opcode == 6'b000000) begin
         dec_legal     = 1'b1;
         dec_write_reg = rd_f;
         case (funct)
            6'b000000: dec_ctl = CTL_SLL;
            6'b000010: dec_ctl = CTL_SRL;
            6'b000011: dec_ctl = CTL_SRA;
            6'b000100: dec_ctl = CTL_SLLV;
            6'b000110: dec_ctl = CTL_SRLV;
            6'b000111: dec_ctl = CTL_SRAV;
            6'b100001: dec_ctl = CTL_ADDU;
            6'b100011: dec_ctl = CTL_SUBU;
            6'b100100: dec_ctl = CTL_AND;
            6'b100101: dec_ctl = CTL_OR;
            6'b100110: dec_ctl = CTL_XOR;
            6'b100111: dec_ctl = CTL_NOR;
            6'b101010: dec_ctl = CTL_SLT;
            6'b001001: begin
               dec_ctl = CTL_JALR;
               // rd of zero means the implicit link register
               if (rd_f == 5'd0) begin
                  dec_write_reg = 5'd31;
               end
            end
            default:   dec_legal = 1'b0;
         endcase
         dec_reg_write = dec_legal;
      end else begin
         dec_legal     = 1'b1;
         dec_src_imm   = 1'b1;
         dec_write_reg = rt_f;
         dec_reg_write = 1'b1;
         case (opcode)
            6'b001001: begin
               dec_ctl = CTL_ADDU;
               dec_imm = {{16{imm16[15]}}, imm16};
            end
            6'b100011: begin
               dec_ctl = CTL_ADDU;
               dec_imm = {{16{imm16[15]}}, imm16};
            end
            6'b101011: begin
               dec_ctl       = CTL_ADDU;
               dec_imm       = {{16{imm16[15]}}, imm16};
               dec_reg_write = 1'b0;
            end
            6'b001010: begin
               dec_ctl = CTL_SLT;
               dec_imm = {{16{imm16[15]}}, imm16};
            end
            6'b001100: begin
               dec_ctl = CTL_AND;
               dec_imm = {16'd0, imm16};
            end
            6'b001101: begin
               dec_ctl = CTL_OR;
               dec_imm = {16'd0, imm16};
            end
            6'b001110: begin
               dec_ctl = CTL_XOR;
               dec_imm = {16'd0, imm16};
            end
            6'b001111: begin
               dec_ctl = CTL_LUI;
               dec_imm = {16'd0, imm16};
            end
            default:   dec_legal = 1'b0;
         endcase
      end

      if (!dec_legal) begin
         dec_ctl       = CTL_ILL;
         dec_reg_write = 1'b0;
         dec_src_imm   = 1'b0;
         dec_write_reg = 5'd0;
         dec_imm       = 32'd0;
      end
   end

   // Pipeline register
   logic        valid_q,     valid_d;
   logic [3:0]  ctl_q,       ctl_d;
   logic [4:0]  shamt_q,     shamt_d;
   logic [4:0]  rs_q,        rs_d;
   logic [4:0]  rt_q,        rt_d;
   logic [4:0]  write_reg_q, write_reg_d;
   logic        reg_write_q, reg_write_d;
   logic        src_imm_q,   src_imm_d;
   logic [31:0] imm_q,       imm_d;
   logic        illegal_q,   illegal_d;

   logic accept;
   logic drain;

   assign o_Ready = !valid_q || i_Ready;
   assign accept  = i_Valid && o_Ready && !i_Flush;
   assign drain   = valid_q && i_Ready;

   always_comb begin
      valid_d     = valid_q;
      ctl_d       = ctl_q;
      shamt_d     = shamt_q;
      rs_d        = rs_q;
      rt_d        = rt_q;
      write_reg_d = write_reg_q;
      reg_write_d = reg_write_q;
      src_imm_d   = src_imm_q;
      imm_d       = imm_q;
      illegal_d   = illegal_q;

      if (i_Flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d = 1'b1;
      end else if (drain) begin
         valid_d = 1'b0;
      end

      if (accept) begin
         ctl_d       = dec_ctl;
         shamt_d     = shamt_f;
         rs_d        = rs_f;
         rt_d        = rt_f;
         write_reg_d = dec_write_reg;
         reg_write_d = dec_reg_write;
         src_imm_d   = dec_src_imm;
         imm_d       = dec_imm;
         illegal_d   = !dec_legal;
      end else if (!valid_d) begin
         // An empty stage never advertises a register write
         reg_write_d = 1'b0;
         illegal_d   = 1'b0;
      end
   end

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         valid_q     <= 1'b0;
         ctl_q       <= 4'd0;
         shamt_q     <= 5'd0;
         rs_q        <= 5'd0;
         rt_q        <= 5'd0;
         write_reg_q <= 5'd0;
         reg_write_q <= 1'b0;
         src_imm_q   <= 1'b0;
         imm_q       <= 32'd0;
         illegal_q   <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         ctl_q       <= ctl_d;
         shamt_q     <= shamt_d;
         rs_q        <= rs_d;
         rt_q        <= rt_d;
         write_reg_q <= write_reg_d;
         reg_write_q <= reg_write_d;
         src_imm_q   <= src_imm_d;
         imm_q       <= imm_d;
         illegal_q   <= illegal_d;
      end
   end

   assign o_Valid       = valid_q;
   assign o_Control     = ctl_q;
   assign o_Shamt       = shamt_q;
   assign o_Rs          = rs_q;
   assign o_Rt          = rt_q;
   assign o_Write_Reg   = write_reg_q;
   assign o_Reg_Write   = reg_write_q;
   assign o_ALU_Src_Imm = src_imm_q;
   assign o_Imm         = imm_q;
   assign o_Illegal     = illegal_q;

`ifdef ILLEGAL_CNT_EN
   // Counts illegal bundles actually handed to EX; a flush cancels the handoff
   logic [CNT_WIDTH-1:0] ill_cnt_q, ill_cnt_d;

   always_comb begin
      ill_cnt_d = ill_cnt_q;
      if (drain && illegal_q && !i_Flush && (ill_cnt_q != {CNT_WIDTH{1'b1}})) begin
         ill_cnt_d = ill_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         ill_cnt_q <= '0;
      end else begin
         ill_cnt_q <= ill_cnt_d;
      end
   end

   assign o_Illegal_Count = ill_cnt_q;
`endif

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Scoreboard bench for alu_ctrl_stage: a reference decoder queues expected bundles at accept, a negedge monitor pops them at transfer.
module tb_alu_ctrl_stage;

   typedef struct packed {
      logic [3:0]  ctl;
      logic [4:0]  shamt;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  wr;
      logic        rw;
      logic        src;
      logic [31:0] imm;
      logic        ill;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_Valid = 1'b0;
   logic [31:0] i_Instruction = 32'd0;
   logic        i_Flush = 1'b0;
   logic        i_Ready = 1'b1;
   logic        o_Ready, o_Valid, o_Reg_Write, o_ALU_Src_Imm, o_Illegal;
   logic [3:0]  o_Control;
   logic [4:0]  o_Shamt, o_Rs, o_Rt, o_Write_Reg;
   logic [31:0] o_Imm;
`ifdef ILLEGAL_CNT_EN
   logic [15:0] o_Illegal_Count;
   int          cnt_model = 0;
`endif

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t q[$];
   logic prev_rw = 1'b0;

   always #5 clk = ~clk;

   alu_ctrl_stage #(.CNT_WIDTH(16)) dut (
      .i_Clock(clk), .i_Reset_n(rst_n),
      .i_Valid(i_Valid), .o_Ready(o_Ready),
      .i_Instruction(i_Instruction), .i_Flush(i_Flush),
      .o_Valid(o_Valid), .i_Ready(i_Ready),
      .o_Control(o_Control), .o_Shamt(o_Shamt), .o_Rs(o_Rs), .o_Rt(o_Rt),
      .o_Write_Reg(o_Write_Reg), .o_Reg_Write(o_Reg_Write),
      .o_ALU_Src_Imm(o_ALU_Src_Imm), .o_Imm(o_Imm), .o_Illegal(o_Illegal)
`ifdef ILLEGAL_CNT_EN
      , .o_Illegal_Count(o_Illegal_Count)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [31:0] w);
      exp_t e;
      logic [5:0] op;
      logic [5:0] fn;
      logic [4:0] rd;
      logic [31:0] sx;
      logic [31:0] zx;
      op = w[31:26];
      fn = w[5:0];
      rd = w[15:11];
      sx = {{16{w[15]}}, w[15:0]};
      zx = {16'h0000, w[15:0]};
      e.rs = w[25:21]; e.rt = w[20:16]; e.shamt = w[10:6];
      e.ctl = 4'd15; e.ill = 1'b1; e.rw = 1'b0; e.src = 1'b0; e.imm = 32'd0; e.wr = 5'd0;
      if (op == 6'd0) begin
         case (fn)
            6'd0:  e.ctl = 4'd0;
            6'd2:  e.ctl = 4'd1;
            6'd3:  e.ctl = 4'd2;
            6'd4:  e.ctl = 4'd3;
            6'd6:  e.ctl = 4'd4;
            6'd7:  e.ctl = 4'd5;
            6'd33: e.ctl = 4'd6;
            6'd35: e.ctl = 4'd7;
            6'd36: e.ctl = 4'd8;
            6'd37: e.ctl = 4'd9;
            6'd38: e.ctl = 4'd10;
            6'd39: e.ctl = 4'd11;
            6'd42: e.ctl = 4'd12;
            6'd9:  e.ctl = 4'd13;
            default: e.ctl = 4'd15;
         endcase
         if (e.ctl != 4'd15) begin
            e.ill = 1'b0;
            e.rw = 1'b1;
            e.wr = (fn == 6'd9 && rd == 5'd0) ? 5'd31 : rd;
         end
      end else begin
         case (op)
            6'd9, 6'd35, 6'd43: begin e.ctl = 4'd6;  e.imm = sx; end
            6'd10:              begin e.ctl = 4'd12; e.imm = sx; end
            6'd12:              begin e.ctl = 4'd8;  e.imm = zx; end
            6'd13:              begin e.ctl = 4'd9;  e.imm = zx; end
            6'd14:              begin e.ctl = 4'd10; e.imm = zx; end
            6'd15:              begin e.ctl = 4'd14; e.imm = zx; end
            default:            e.ctl = 4'd15;
         endcase
         if (e.ctl != 4'd15) begin
            e.ill = 1'b0;
            e.src = 1'b1;
            e.wr = w[20:16];
            e.rw = (op != 6'd43);
         end
      end
      return e;
   endfunction

   // Monitor: compare the head of the queue while the bundle is presented, pop on transfer or flush
   always @(negedge clk) begin
      if (rst_n) begin
         chk("ready_rule", {31'd0, o_Ready}, {31'd0, (!o_Valid || i_Ready)});
         chk("valid_occupancy", {31'd0, o_Valid}, {31'd0, (q.size() != 0)});
`ifdef ILLEGAL_CNT_EN
         chk("ill_count", {16'd0, o_Illegal_Count}, cnt_model);
`endif
         if (!o_Valid) begin
            chk("rw_idle", {31'd0, (o_Reg_Write && !prev_rw)}, 32'd0);
         end
         if (o_Valid && q.size() != 0) begin
            chk("ctl", {28'd0, o_Control}, {28'd0, q[0].ctl});
            chk("illegal", {31'd0, o_Illegal}, {31'd0, q[0].ill});
            chk("reg_write", {31'd0, o_Reg_Write}, {31'd0, q[0].rw});
            chk("rs", {27'd0, o_Rs}, {27'd0, q[0].rs});
            chk("rt", {27'd0, o_Rt}, {27'd0, q[0].rt});
            chk("shamt", {27'd0, o_Shamt}, {27'd0, q[0].shamt});
            if (!q[0].ill) begin
               chk("write_reg", {27'd0, o_Write_Reg}, {27'd0, q[0].wr});
               chk("src_imm", {31'd0, o_ALU_Src_Imm}, {31'd0, q[0].src});
               chk("imm", o_Imm, q[0].imm);
            end
            if (i_Flush) begin
               $display("xfer flushed ctl=%0d", q[0].ctl);
               void'(q.pop_front());
            end else if (i_Ready) begin
               $display("xfer out ctl=%0d wr=%0d rw=%0b imm=0x%08h ill=%0b", o_Control, o_Write_Reg, o_Reg_Write, o_Imm, o_Illegal);
`ifdef ILLEGAL_CNT_EN
               if (q[0].ill && cnt_model != 32'hFFFF) cnt_model++;
`endif
               void'(q.pop_front());
            end
         end
         if (i_Valid && o_Ready && !i_Flush) begin
            q.push_back(model(i_Instruction));
         end
      end
      prev_rw = o_Reg_Write;
   end

   task automatic step(input logic v, input logic [31:0] w, input logic r, input logic f);
      i_Valid = v;
      i_Instruction = w;
      i_Ready = r;
      i_Flush = f;
      @(posedge clk);
      #1;
   endtask

   logic [5:0] fn_list [15] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd33, 6'd35,
                                6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd9, 6'd1};
   logic [5:0] op_list [10] = '{6'd0, 6'd9, 6'd35, 6'd43, 6'd10, 6'd12, 6'd13, 6'd14, 6'd15, 6'd63};

   initial begin
      logic [31:0] w;
      // Reset state
      #3;
      chk("rst_valid", {31'd0, o_Valid}, 32'd0);
      chk("rst_ctl", {28'd0, o_Control}, 32'd0);
      chk("rst_imm", o_Imm, 32'd0);
      chk("rst_rw", {31'd0, o_Reg_Write}, 32'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ADDU rs=4 rt=5 rd=2
      step(1'b1, 32'h00851021, 1'b1, 1'b0);
      chk("addu_valid", {31'd0, o_Valid}, 32'd1);
      chk("addu_ctl", {28'd0, o_Control}, 32'd6);
      chk("addu_wr", {27'd0, o_Write_Reg}, 32'd2);
      chk("addu_src", {31'd0, o_ALU_Src_Imm}, 32'd0);

      // ADDIU / ORI back to back with 0xFFFC
      step(1'b1, 32'h2401FFFC, 1'b1, 1'b0);
      chk("addiu_imm", o_Imm, 32'hFFFFFFFC);
      step(1'b1, 32'h3401FFFC, 1'b1, 1'b0);
      chk("ori_imm", o_Imm, 32'h0000FFFC);
      chk("ori_ctl", {28'd0, o_Control}, 32'd9);
      chk("ori_no_bubble", {31'd0, o_Valid}, 32'd1);

      // Stall three cycles, then release
      step(1'b1, 32'h00A62022, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 32'h00A62025, 1'b0, 1'b0);
         chk("stall_ready", {31'd0, o_Ready}, 32'd0);
         chk("stall_hold", {28'd0, o_Control}, 32'd9);
      end
      step(1'b1, 32'h00A62025, 1'b1, 1'b0);
      chk("stall_first", {28'd0, o_Control}, 32'd9);
      step(1'b0, 32'd0, 1'b1, 1'b0);
      chk("stall_next", {28'd0, o_Control}, 32'd9);
      chk("stall_next_rd", {27'd0, o_Write_Reg}, 32'd4);

      // Illegal opcode, then the same word flushed
      step(1'b1, 32'hFC000000, 1'b1, 1'b0);
      chk("ill_flag", {31'd0, o_Illegal}, 32'd1);
      chk("ill_ctl", {28'd0, o_Control}, 32'd15);
      step(1'b1, 32'hFC000000, 1'b1, 1'b1);
      chk("flush_valid", {31'd0, o_Valid}, 32'd0);
      step(1'b0, 32'd0, 1'b1, 1'b0);

      // JALR rd=0 and SW
      step(1'b1, 32'h00600009, 1'b1, 1'b0);
      chk("jalr_ctl", {28'd0, o_Control}, 32'd13);
      chk("jalr_wr", {27'd0, o_Write_Reg}, 32'd31);
      step(1'b1, 32'hAC430004, 1'b1, 1'b0);
      chk("sw_ctl", {28'd0, o_Control}, 32'd6);
      chk("sw_rw", {31'd0, o_Reg_Write}, 32'd0);
      step(1'b0, 32'd0, 1'b1, 1'b0);

      // Random traffic
      for (int n = 0; n < 300; n++) begin
         w = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            w[31:26] = op_list[$urandom_range(0, 9)];
            if (w[31:26] == 6'd0) w[5:0] = fn_list[$urandom_range(0, 14)];
         end
         step($urandom_range(0, 3) != 0, w, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
      end
      step(1'b0, 32'd0, 1'b1, 1'b0);
      step(1'b0, 32'd0, 1'b1, 1'b0);

      // Reset in the middle of a stall
      step(1'b1, 32'h00851021, 1'b1, 1'b0);
      i_Valid = 1'b0;
      i_Ready = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      q.delete();
`ifdef ILLEGAL_CNT_EN
      cnt_model = 0;
      chk("rst_cnt", {16'd0, o_Illegal_Count}, 32'd0);
`endif
      chk("midrst_valid", {31'd0, o_Valid}, 32'd0);
      chk("midrst_ctl", {28'd0, o_Control}, 32'd0);
      chk("midrst_wr", {27'd0, o_Write_Reg}, 32'd0);
      chk("midrst_rw", {31'd0, o_Reg_Write}, 32'd0);
      chk("midrst_rs", {27'd0, o_Rs}, 32'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      step(1'b1, 32'h3401FFFC, 1'b1, 1'b0);
      chk("postrst_valid", {31'd0, o_Valid}, 32'd1);
      chk("postrst_ctl", {28'd0, o_Control}, 32'd9);
      step(1'b0, 32'd0, 1'b1, 1'b0);
      step(1'b0, 32'd0, 1'b1, 1'b0);
      chk("drain_empty", q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_ctrl_stage.md
ALU_CTRL_STAGE -- requirements
Module: alu_ctrl_stage

Interface
REQ-001 SHALL have parameter: CNT_WIDTH, 16, width of illegal-instruction counter.
REQ-002 SHALL have ports: i_Clock  in  1  sole clock, rising edge.
REQ-003 SHALL have ports: i_Reset_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: i_Valid  in  1  upstream instruction valid; o_Ready  out  1  stage can accept.
REQ-005 SHALL have ports: i_Instruction  in  32  MIPS word; i_Flush  in  1  kill held and incoming instruction.
REQ-006 SHALL have ports: o_Valid  out  1  decoded bundle valid; i_Ready  in  1  EX stage accepts.
REQ-007 SHALL have ports: o_Control  out  4  ALU op code; o_Shamt  out  5  instr[10:6]; o_Rs, o_Rt  out  5  each.
REQ-008 SHALL have ports: o_Write_Reg  out  5  destination; o_Reg_Write  out  1; o_ALU_Src_Imm  out  1; o_Imm  out  32; o_Illegal  out  1.
REQ-009 SHALL have port o_Illegal_Count  out  CNT_WIDTH, present only when ILLEGAL_CNT_EN is defined.

Function
REQ-010 o_Control codes SHALL be: SLL 0, SRL 1, SRA 2, SLLV 3, SRLV 4, SRAV 5, ADDU 6, SUBU 7, AND 8, OR 9, XOR 10, NOR 11, SLT 12, JALR 13, LUI 14; illegal 15.
REQ-011 opcode 000000 SHALL decode funct: 000000 SLL, 000010 SRL, 000011 SRA, 000100 SLLV, 000110 SRLV, 000111 SRAV, 100001 ADDU, 100011 SUBU, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT, 001001 JALR; o_Write_Reg = rd, o_ALU_Src_Imm = 0.
REQ-012 I-type SHALL decode: ADDIU 001001, LW 100011, SW 101011 -> ADDU; SLTI 001010 -> SLT; ANDI 001100 -> AND; ORI 001101 -> OR; XORI 001110 -> XOR; LUI 001111 -> LUI; o_ALU_Src_Imm = 1, o_Write_Reg = rt.
REQ-013 o_Imm SHALL be sign-extended instr[15:0] for ADDIU/SLTI/LW/SW, zero-extended for ANDI/ORI/XORI/LUI, 0 for R-type.
REQ-014 o_Reg_Write SHALL be 1 for all legal decodes except SW; 0 for SW and illegal.
REQ-015 JALR SHALL set o_Write_Reg = rd, or 31 when rd field is 0.
REQ-016 Any other opcode/funct SHALL give o_Illegal = 1, o_Control = 15, o_Reg_Write = 0; bundle still passes with o_Valid.
REQ-017 Stage SHALL be one register deep; latency exactly one cycle from accepted input to o_Valid.
REQ-018 o_Ready SHALL equal (!o_Valid || i_Ready), combinational; transfer in when i_Valid && o_Ready.
REQ-019 Outputs SHALL hold stable while o_Valid && !i_Ready (stall); no instruction lost or duplicated.
REQ-020 Simultaneous accept-in and drain-out SHALL replace the bundle same edge; o_Valid stays 1, full throughput.
REQ-021 i_Flush SHALL clear o_Valid next edge and discard any same-cycle input; flush overrides i_Valid and stall.
REQ-022 When o_Valid = 0 the data outputs SHALL be don't-care but must not change o_Reg_Write to 1.

Reset
REQ-023 i_Reset_n low SHALL asynchronously clear o_Valid, o_Reg_Write, o_Illegal, o_ALU_Src_Imm, all fields, o_Imm to 0, o_Control to 0.
REQ-024 Reset mid-stall SHALL drop the held bundle; first post-reset edge with i_Valid SHALL accept normally.

Configuration
REQ-025 With ILLEGAL_CNT_EN defined, o_Illegal_Count SHALL increment on each edge where an illegal bundle transfers out (o_Valid && i_Ready && o_Illegal), saturate at all-ones, clear on reset; flushed illegal bundles SHALL not count.
REQ-026 Without ILLEGAL_CNT_EN, the counter and port SHALL be absent; all other behaviour identical.

Verification
REQ-027 0x00851021-style ADDU (rs=4, rt=5, rd=2, funct 100001), i_Ready=1 -> next cycle o_Valid=1, o_Control=6, o_Write_Reg=2, o_Reg_Write=1, o_ALU_Src_Imm=0.
REQ-028 ADDIU imm 0xFFFC then ORI imm 0xFFFC back-to-back -> o_Imm 0xFFFFFFFC then 0x0000FFFC, control 6 then 9, no bubble.
REQ-029 Hold i_Ready=0 three cycles with i_Valid=1 -> o_Ready=0, outputs unchanged; release -> next instruction follows in one cycle.
REQ-030 Opcode 111111 with ILLEGAL_CNT_EN -> o_Illegal=1, o_Control=15, o_Reg_Write=0, counter 0->1; same with i_Flush -> counter stays 1.
REQ-031 JALR rd=0 -> o_Control=13, o_Write_Reg=31; SW -> o_Control=6, o_Reg_Write=0.
REQ-032 Assert i_Reset_n=0 mid-stall between edges -> o_Valid=0 immediately, all outputs 0.
